// File: rtl/wisc_mem_pkg.sv
// Shared types and constants for the WISC unified-memory arbiter and its helpers.
package wisc_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arb_state_t;

   // Read data returned to the owning port when the memory never answers
   localparam logic [15:0] MEM_ERR_DATA = 16'hFFFF;

   localparam int DEF_STARVE_MAX = 3;
   localparam int DEF_TIMEOUT    = 15;

endpackage

// File: rtl/mem_watchdog.sv
// Loadable up-counter with clear and terminal-count detect; shared by the
// arbiter and the cache miss handler to catch a memory that never answers.
module mem_watchdog #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             inc,
   input  logic [WIDTH-1:0] term_val,
   output logic             tc
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (ld) begin
         count <= ld_val;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   // tc fires in the cycle whose increment would take the count past term_val
   assign tc = inc && (count == term_val);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data
// access, with fetch-starvation override and a watchdog for hung memory.
module mem_arbiter
   import wisc_mem_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic [15:0] if_rdata,
   output logic        if_ready,
   input  logic        d_re,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_rdata,
   output logic        d_ready,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_valid,
   output logic        err
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   arb_state_t state, next_state;

   logic          if_elig, d_elig, starve_hit;
   logic          grant_i, grant_d, done, timeout, finish, wd_tc;
   logic [SW-1:0] starve_cnt;
   logic [15:0]   lat_addr, lat_wdata, resp_data;
   logic          lat_we;

   // A port whose ready is pulsing still holds req from the finished access
   assign if_elig    = if_req && !if_ready;
   assign d_elig     = (d_re || d_we) && !d_ready;
   assign starve_hit = (starve_cnt == SW'(STARVE_MAX)) && if_elig;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      done       = 1'b0;
      timeout    = 1'b0;
      unique case (state)
         IDLE: begin
            if (d_elig && !starve_hit) begin
               grant_d    = 1'b1;
               next_state = BUSY_D;
            end else if (if_elig) begin
               grant_i    = 1'b1;
               next_state = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_valid) begin
               done       = 1'b1;
               next_state = IDLE;
            end else if (wd_tc) begin
               timeout    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign finish    = done || timeout;
   assign resp_data = done ? mem_rdata : MEM_ERR_DATA;

   mem_watchdog #(
      .WIDTH (CW)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clr      (grant_i || grant_d),
      .ld       (1'b0),
      .ld_val   ('0),
      .inc      (state != IDLE),
      .term_val (CW'(TIMEOUT - 1)),
      .tc       (wd_tc)
   );

   // Request fields are captured only at the grant edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_addr  <= 16'h0000;
         lat_wdata <= 16'h0000;
         lat_we    <= 1'b0;
      end else if (grant_d) begin
         lat_addr  <= d_addr;
         lat_wdata <= d_wdata;
         lat_we    <= d_we;
      end else if (grant_i) begin
         lat_addr  <= if_addr;
         lat_we    <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_ready <= 1'b0;
         d_ready  <= 1'b0;
         if_rdata <= 16'h0000;
         d_rdata  <= 16'h0000;
         err      <= 1'b0;
      end else begin
         if_ready <= finish && (state == BUSY_I);
         d_ready  <= finish && (state == BUSY_D);
         if (finish && (state == BUSY_I)) begin
            if_rdata <= resp_data;
         end
         if (finish && (state == BUSY_D) && (timeout || !lat_we)) begin
            d_rdata <= resp_data;
         end
         if (timeout) begin
            err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant_i) begin
         starve_cnt <= '0;
      end else if (grant_d) begin
         if (!if_req) begin
            starve_cnt <= '0;
         end else if (starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

   assign mem_en    = (state != IDLE);
   assign mem_we    = mem_en && lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

   localparam int SMAX = 3;
   localparam int TOUT = 15;

   logic        clk, rst;
   logic        if_req, d_re, d_we, mem_valid;
   logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_ready, d_ready, mem_en, mem_we, err;

   int compared   = 0;
   int mismatched = 0;

   mem_arbiter #(
      .STARVE_MAX (SMAX),
      .TIMEOUT    (TOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ready  (if_ready),
      .d_re      (d_re),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: who owns the port, how long it has been waiting,
   // what was captured at the grant, and what the ports should see.
   int          m_owner;
   int          m_elapsed;
   int          m_starve;
   logic [15:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
   logic        m_we, m_if_ready, m_d_ready, m_err;

   int          resp_at;
   logic        resp_hang;
   logic [15:0] resp_data;

   int          forced_lat;
   logic        force_data_en;
   logic [15:0] forced_data;
   logic        hang_next, hang_rand, stray_en, stray_once, rand_addr;
   int          if_pct, d_pct;
   logic        if_drop, d_drop;

   logic        obs_mem_en, obs_mem_we, obs_if_ready, obs_d_ready, obs_err;
   logic [15:0] obs_mem_addr, obs_mem_wdata, obs_if_rdata, obs_d_rdata;

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkInt(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_owner    = 0;
      m_elapsed  = 0;
      m_starve   = 0;
      m_addr     = 16'h0000;
      m_wdata    = 16'h0000;
      m_we       = 1'b0;
      m_if_rdata = 16'h0000;
      m_d_rdata  = 16'h0000;
      m_if_ready = 1'b0;
      m_d_ready  = 1'b0;
      m_err      = 1'b0;
      resp_hang  = 1'b0;
      resp_at    = 1;
      resp_data  = 16'h0000;
   endtask

   task automatic checkOutput();
      obs_mem_en    = mem_en;
      obs_mem_we    = mem_we;
      obs_mem_addr  = mem_addr;
      obs_mem_wdata = mem_wdata;
      obs_if_ready  = if_ready;
      obs_d_ready   = d_ready;
      obs_if_rdata  = if_rdata;
      obs_d_rdata   = d_rdata;
      obs_err       = err;
      check1("mem_en", mem_en, m_owner != 0);
      check1("mem_we", mem_we, (m_owner != 0) && m_we);
      check16("mem_addr", mem_addr, m_addr);
      if ((m_owner != 0) && m_we) begin
         check16("mem_wdata", mem_wdata, m_wdata);
      end
      check1("if_ready", if_ready, m_if_ready);
      check1("d_ready", d_ready, m_d_ready);
      check16("if_rdata", if_rdata, m_if_rdata);
      check16("d_rdata", d_rdata, m_d_rdata);
      check1("err", err, m_err);
   endtask

   // Requesters hold req through their ready cycle and drop it the cycle
   // after; the memory answers the model's current owner after resp_at cycles.
   task automatic applyStimulus();
      int kind;
      if (if_drop) begin
         if_req  = 1'b0;
         if_drop = 1'b0;
      end
      if (m_if_ready) if_drop = 1'b1;
      if (!if_req && int'($urandom_range(0, 99)) < if_pct) begin
         if_req  = 1'b1;
         if_addr = 16'($urandom);
      end
      if (d_drop) begin
         d_re   = 1'b0;
         d_we   = 1'b0;
         d_drop = 1'b0;
      end
      if (m_d_ready) d_drop = 1'b1;
      if (!d_re && !d_we && int'($urandom_range(0, 99)) < d_pct) begin
         kind    = int'($urandom_range(0, 2));
         d_re    = (kind != 1);
         d_we    = (kind != 0);
         d_addr  = 16'($urandom);
         d_wdata = 16'($urandom);
      end
      if (rand_addr) begin
         if_addr = 16'($urandom);
         d_addr  = 16'($urandom);
         d_wdata = 16'($urandom);
      end
      mem_valid = 1'b0;
      mem_rdata = 16'($urandom);
      if (m_owner != 0) begin
         if (!resp_hang && m_elapsed == resp_at) begin
            mem_valid = 1'b1;
            mem_rdata = resp_data;
         end
      end else if (stray_once || (stray_en && $urandom_range(0, 9) == 0)) begin
         mem_valid  = 1'b1;
         stray_once = 1'b0;
      end
   endtask

   task automatic pickResponse();
      resp_at   = (forced_lat > 0) ? forced_lat : int'($urandom_range(1, 5));
      resp_hang = hang_next || (hang_rand && $urandom_range(0, 39) == 0);
      hang_next = 1'b0;
      resp_data = force_data_en ? forced_data : 16'($urandom);
   endtask

   task automatic modelStep();
      logic if_el, d_el, to;
      logic [15:0] data;
      m_if_ready = 1'b0;
      m_d_ready  = 1'b0;
      if (m_owner == 0) begin
         if_el = if_req && !(obs_if_ready);
         d_el  = (d_re || d_we) && !(obs_d_ready);
         if (d_el && !(m_starve == SMAX && if_el)) begin
            m_owner   = 2;
            m_addr    = d_addr;
            m_wdata   = d_wdata;
            m_we      = d_we;
            m_starve  = if_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
            m_elapsed = 1;
            pickResponse();
         end else if (if_el) begin
            m_owner   = 1;
            m_addr    = if_addr;
            m_we      = 1'b0;
            m_starve  = 0;
            m_elapsed = 1;
            pickResponse();
         end
      end else begin
         to   = !mem_valid && (m_elapsed == TOUT);
         data = mem_valid ? mem_rdata : 16'hFFFF;
         if (mem_valid || to) begin
            if (m_owner == 1) begin
               m_if_ready = 1'b1;
               m_if_rdata = data;
            end else begin
               m_d_ready = 1'b1;
               if (!m_we || to) m_d_rdata = data;
            end
            if (to) m_err = 1'b1;
            m_owner = 0;
         end else begin
            m_elapsed++;
         end
      end
   endtask

   task automatic runCycle();
      @(negedge clk);
      checkOutput();
      applyStimulus();
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) runCycle();
   endtask

   initial begin
      int   cnt, cnt2, cyc;
      logic found;

      rst = 1'b1;
      if_req = 1'b0; d_re = 1'b0; d_we = 1'b0; mem_valid = 1'b0;
      if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; mem_rdata = 16'h0;
      forced_lat = -1; force_data_en = 1'b0; forced_data = 16'h0;
      hang_next = 1'b0; hang_rand = 1'b0; stray_en = 1'b0; stray_once = 1'b0;
      rand_addr = 1'b0; if_pct = 0; d_pct = 0; if_drop = 1'b0; d_drop = 1'b0;
      obs_if_ready = 1'b0; obs_d_ready = 1'b0;
      modelReset();

      repeat (2) @(posedge clk);
      @(negedge clk);
      check1("rst_mem_en", mem_en, 1'b0);
      check1("rst_mem_we", mem_we, 1'b0);
      check1("rst_if_ready", if_ready, 1'b0);
      check1("rst_d_ready", d_ready, 1'b0);
      check1("rst_err", err, 1'b0);
      check16("rst_mem_addr", mem_addr, 16'h0000);
      check16("rst_mem_wdata", mem_wdata, 16'h0000);
      check16("rst_if_rdata", if_rdata, 16'h0000);
      check16("rst_d_rdata", d_rdata, 16'h0000);
      @(posedge clk);
      #2 rst = 1'b0;

      $display("[TB] single fetch");
      forced_lat = 3; force_data_en = 1'b1; forced_data = 16'hB123;
      if_req = 1'b1; if_addr = 16'h0004;
      cnt = 0; found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         runCycle();
         if (obs_mem_en) cnt++;
         if (obs_if_ready) found = 1'b1;
      end
      check1("t1_done", found, 1'b1);
      checkInt("t1_en_cycles", cnt, 3);
      check16("t1_rdata", obs_if_rdata, 16'hB123);
      settle(3);
      check1("t1_idle", obs_mem_en, 1'b0);

      $display("[TB] simultaneous fetch and load");
      forced_lat = 1; forced_data = 16'hC0DE;
      if_req = 1'b1; if_addr = 16'h0040;
      d_re = 1'b1; d_addr = 16'h0010;
      runCycle();
      runCycle();
      check16("t2_data_first", obs_mem_addr, 16'h0010);
      runCycle();
      check1("t2_d_ready", obs_d_ready, 1'b1);
      runCycle();
      check1("t2_fetch_busy", obs_mem_en, 1'b1);
      check16("t2_fetch_addr", obs_mem_addr, 16'h0040);
      settle(4);

      $display("[TB] store");
      forced_lat = 2;
      d_we = 1'b1; d_re = 1'b0; d_addr = 16'h0020; d_wdata = 16'h5A5A;
      runCycle();
      d_addr = 16'hFFFF; d_wdata = 16'h0000;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         runCycle();
         if (obs_mem_en) begin
            check1("t3_mem_we", obs_mem_we, 1'b1);
            check16("t3_mem_addr", obs_mem_addr, 16'h0020);
            check16("t3_mem_wdata", obs_mem_wdata, 16'h5A5A);
         end
         if (obs_d_ready) found = 1'b1;
      end
      check1("t3_done", found, 1'b1);
      check16("t3_rdata_kept", obs_d_rdata, 16'hC0DE);
      settle(3);

      $display("[TB] data stream with fetch pending");
      forced_lat = -1; force_data_en = 1'b0;
      d_pct = 100;
      if_req = 1'b1; if_addr = 16'h0100;
      cnt = 0; found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         runCycle();
         if (obs_d_ready) cnt++;
         if (obs_if_ready) found = 1'b1;
      end
      check1("t4_fetch_done", found, 1'b1);
      check1("t4_starve_bound", cnt <= SMAX, 1'b1);
      d_pct = 0;
      settle(15);

      $display("[TB] watchdog");
      hang_next = 1'b1;
      d_re = 1'b1; d_addr = 16'h0200;
      found = 1'b0; cyc = -1;
      for (int i = 0; i < 40; i++) begin
         runCycle();
         if (obs_d_ready) begin
            found = 1'b1;
            cyc = i;
            break;
         end
      end
      check1("t5_ready", found, 1'b1);
      checkInt("t5_latency", cyc, TOUT + 1);
      check16("t5_rdata", obs_d_rdata, 16'hFFFF);
      check1("t5_err", obs_err, 1'b1);
      settle(2);
      forced_lat = 1; force_data_en = 1'b1; forced_data = 16'h1234;
      if_req = 1'b1; if_addr = 16'h0300;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         runCycle();
         if (obs_if_ready) found = 1'b1;
      end
      check1("t5_next_done", found, 1'b1);
      check16("t5_next_rdata", obs_if_rdata, 16'h1234);
      check1("t5_err_sticky", obs_err, 1'b1);
      settle(3);

      $display("[TB] reset during data access");
      forced_lat = 4;
      d_re = 1'b1; d_addr = 16'h0300;
      runCycle();
      runCycle();
      #1 rst = 1'b1;
      #1;
      check1("t6_mem_en", mem_en, 1'b0);
      check1("t6_mem_we", mem_we, 1'b0);
      check1("t6_d_ready", d_ready, 1'b0);
      check1("t6_if_ready", if_ready, 1'b0);
      check1("t6_err", err, 1'b0);
      check16("t6_mem_addr", mem_addr, 16'h0000);
      check16("t6_mem_wdata", mem_wdata, 16'h0000);
      check16("t6_if_rdata", if_rdata, 16'h0000);
      check16("t6_d_rdata", d_rdata, 16'h0000);
      d_re = 1'b0; if_req = 1'b0; if_drop = 1'b0; d_drop = 1'b0;
      obs_if_ready = 1'b0; obs_d_ready = 1'b0;
      modelReset();
      @(posedge clk);
      #2 rst = 1'b0;
      stray_once = 1'b1;
      cnt2 = 0;
      for (int i = 0; i < 6; i++) begin
         runCycle();
         if (obs_d_ready || obs_if_ready || obs_mem_en) cnt2++;
      end
      checkInt("t6_quiet", cnt2, 0);

      $display("[TB] random traffic");
      forced_lat = -1; force_data_en = 1'b0;
      if_pct = 35; d_pct = 35; rand_addr = 1'b1; stray_en = 1'b1; hang_rand = 1'b1;
      settle(800);
      if_pct = 0; d_pct = 0; rand_addr = 1'b0; stray_en = 1'b0; hang_rand = 1'b0;
      settle(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
